// File: rtl/ttl_mux_scanner_if.sv
// Signal bundle between the scanner and the ttl74x153 path / its requester.
// The parity lines exist only when MUX_SCANNER_PARITY_EN is defined.
interface ttl_mux_scanner_if;
    logic       start;
    logic       y1;
    logic       y2;
    logic       a;
    logic       b;
    logic       enable1;
    logic       enable2;
    logic [3:0] data1;
    logic [3:0] data2;
    logic       valid;
    logic       busy;
`ifdef MUX_SCANNER_PARITY_EN
    logic [1:0] parity;
`endif

    modport master (
`ifdef MUX_SCANNER_PARITY_EN
        output parity,
`endif
        input  start, y1, y2,
        output a, b, enable1, enable2, data1, data2, valid, busy
    );

    modport slave (
`ifdef MUX_SCANNER_PARITY_EN
        input  parity,
`endif
        output start, y1, y2,
        input  a, b, enable1, enable2, data1, data2, valid, busy
    );
endinterface

// File: rtl/ttl_mux_scanner.sv
// Steps a ttl74x153 select through 0..3, settles, samples y1/y2 into 4-bit words.
// Define MUX_SCANNER_PARITY_EN to add a registered parity output latched with valid.
module ttl_mux_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    ttl_mux_scanner_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // With no settle time the scanner goes straight from select change to sampling.
    localparam logic [3:0] CNT_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam state_t     STEP     = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic [3:0] data1_q, data1_d;
    logic [3:0] data2_q, data2_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            en_q    <= 1'b1;
            data1_q <= 4'd0;
            data2_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        data1_d = data1_q;
        data2_d = data2_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d   = 2'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = STEP;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SAMPLE: begin
                data1_d[sel_q] = bus.y1;
                data2_d[sel_q] = bus.y2;
                if (sel_q == 2'd3) begin
                    // Outputs are registered, so DONE's view is set on the way in.
                    valid_d = 1'b1;
                    en_d    = 1'b1;
                    sel_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = CNT_INIT;
                    state_d = STEP;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MUX_SCANNER_PARITY_EN
    logic [1:0] parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        parity_q <= 2'd0;
        else if (valid_d) parity_q <= {^data2_d, ^data1_d};
    end

    assign bus.parity = parity_q;
`endif

    assign bus.a       = sel_q[0];
    assign bus.b       = sel_q[1];
    assign bus.enable1 = en_q;
    assign bus.enable2 = en_q;
    assign bus.data1   = data1_q;
    assign bus.data2   = data2_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ttl_mux_scanner.sv
// Randomized bench for ttl_mux_scanner: two instances (settle 1 and 0) behind a modelled
// ttl74x153; expected timing and words come from the scan rules, not from the RTL.
module tb_ttl_mux_scanner;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic       st[2];
    logic [3:0] cw1[2];
    logic [3:0] cw2[2];

    ttl_mux_scanner_if if0 ();
    ttl_mux_scanner_if if1 ();

    // ttl74x153 model: an enabled group drives the selected input, a disabled one drives 0.
    assign if0.start = st[0];
    assign if0.y1    = !if0.enable1 && cw1[0][{if0.b, if0.a}];
    assign if0.y2    = !if0.enable2 && cw2[0][{if0.b, if0.a}];
    assign if1.start = st[1];
    assign if1.y1    = !if1.enable1 && cw1[1][{if1.b, if1.a}];
    assign if1.y2    = !if1.enable2 && cw2[1][{if1.b, if1.a}];

    ttl_mux_scanner #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .reset(rst), .bus(if0));
    ttl_mux_scanner #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .reset(rst), .bus(if1));

    logic [1:0] sel_o[2];
    logic       en1_o[2], en2_o[2], vld_o[2], bsy_o[2];
    logic [3:0] d1_o[2], d2_o[2];

    assign sel_o[0] = {if0.b, if0.a};
    assign en1_o[0] = if0.enable1;
    assign en2_o[0] = if0.enable2;
    assign vld_o[0] = if0.valid;
    assign bsy_o[0] = if0.busy;
    assign d1_o[0]  = if0.data1;
    assign d2_o[0]  = if0.data2;
    assign sel_o[1] = {if1.b, if1.a};
    assign en1_o[1] = if1.enable1;
    assign en2_o[1] = if1.enable2;
    assign vld_o[1] = if1.valid;
    assign bsy_o[1] = if1.busy;
    assign d1_o[1]  = if1.data1;
    assign d2_o[1]  = if1.data2;

`ifdef MUX_SCANNER_PARITY_EN
    logic [1:0] par_o[2];
    assign par_o[0] = if0.parity;
    assign par_o[1] = if1.parity;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int settle(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk_reset_vals(input int d);
        chk("rst_sel", int'(sel_o[d]), 0);
        chk("rst_en1", int'(en1_o[d]), 1);
        chk("rst_en2", int'(en2_o[d]), 1);
        chk("rst_d1", int'(d1_o[d]), 0);
        chk("rst_d2", int'(d2_o[d]), 0);
        chk("rst_vld", int'(vld_o[d]), 0);
        chk("rst_bsy", int'(bsy_o[d]), 0);
`ifdef MUX_SCANNER_PARITY_EN
        chk("rst_par", int'(par_o[d]), 0);
`endif
    endtask

    // One scan; with noise, start toggles randomly while busy and must be ignored.
    task automatic run_scan(input int d, input logic [3:0] v1, input logic [3:0] v2,
                            input bit noise);
        int per = settle(d) + 1;
        int len = 4 * per;
        cw1[d] = v1;
        cw2[d] = v2;
        chk("idle_bsy", int'(bsy_o[d]), 0);
        st[d] = 1'b1;
        @(negedge clk);
        for (int j = 0; j < len; j++) begin
            st[d] = noise ? 1'($urandom) : 1'b0;
            chk("scan_sel", int'(sel_o[d]), j / per);
            chk("scan_en", int'({en1_o[d], en2_o[d]}), 0);
            chk("scan_bsy", int'(bsy_o[d]), 1);
            chk("scan_vld", int'(vld_o[d]), 0);
            @(negedge clk);
        end
        st[d] = noise ? 1'($urandom) : 1'b0;
        chk("done_vld", int'(vld_o[d]), 1);
        chk("done_d1", int'(d1_o[d]), int'(v1));
        chk("done_d2", int'(d2_o[d]), int'(v2));
        chk("done_bsy", int'(bsy_o[d]), 1);
        chk("done_en", int'({en1_o[d], en2_o[d]}), 3);
        chk("done_sel", int'(sel_o[d]), 0);
`ifdef MUX_SCANNER_PARITY_EN
        chk("done_par", int'(par_o[d]), int'({^v2, ^v1}));
`endif
        @(negedge clk);
        st[d] = 1'b0;
        chk("post_vld", int'(vld_o[d]), 0);
        chk("post_bsy", int'(bsy_o[d]), 0);
        @(negedge clk);
        chk("hold_bsy", int'(bsy_o[d]), 0);
        chk("hold_d1", int'(d1_o[d]), int'(v1));
        chk("hold_d2", int'(d2_o[d]), int'(v2));
    endtask

    // start held high: scans repeat with exactly one IDLE cycle between them.
    task automatic run_held(input int d);
        int len = 4 * (settle(d) + 1);
        cw1[d] = 4'($urandom);
        cw2[d] = 4'($urandom);
        st[d] = 1'b1;
        @(negedge clk);
        for (int t = 0; t <= 3 * len + 4; t++) begin
            bit ev = (t == len) || (t == 2 * len + 2) || (t == 3 * len + 4);
            bit eb = !((t == len + 1) || (t == 2 * len + 3));
            chk("held_vld", int'(vld_o[d]), int'(ev));
            chk("held_bsy", int'(bsy_o[d]), int'(eb));
            if (ev) chk("held_d1", int'(d1_o[d]), int'(cw1[d]));
            if (t == 3 * len + 4) st[d] = 1'b0;
            @(negedge clk);
        end
        chk("held_end", int'(bsy_o[d]), 0);
    endtask

    // Reset mid-clock after sample 2 has been captured: everything clears at once.
    task automatic run_abort(input int d);
        int per = settle(d) + 1;
        cw1[d] = 4'hF;
        cw2[d] = 4'hF;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
        repeat (3 * per) @(negedge clk);
        chk("pre_abort_bsy", int'(bsy_o[d]), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4 * per + 2; k++) begin
            @(negedge clk);
            chk("abort_vld", int'(vld_o[d]), 0);
            chk("abort_d1", int'(d1_o[d]), 0);
        end
    endtask

    initial begin
        st[0] = 1'b0;
        st[1] = 1'b0;
        cw1[0] = 4'h0; cw2[0] = 4'h0;
        cw1[1] = 4'h0; cw2[1] = 4'h0;
        rst = 1'b1;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_scan(0, 4'hA, 4'h6, 1'b0);
        run_scan(1, 4'hF, 4'h0, 1'b0);
        run_scan(0, 4'hA, 4'h7, 1'b0);
        run_scan(1, 4'hA, 4'h7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_scan(i % 2, 4'($urandom), 4'($urandom), 1'b1);
        end
        run_held(0);
        run_held(1);
        run_abort(0);
        run_scan(0, 4'h5, 4'hC, 1'b0);
        run_abort(1);
        run_scan(1, 4'h3, 4'h9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
